// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM encoding and the
// parameter bounds checked at elaboration.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int NREQ_MIN     = 2;
  localparam int NREQ_MAX     = 16;
  localparam int MAX_HOLD_MIN = 2;
  localparam int MAX_HOLD_MAX = 255;

endpackage

// File: rtl/tri_bus_arbiter_rr_priority.sv
// Round-robin priority selector: first set request at or above ptr, wrapping
// modulo NREQ. Purely combinational.
module rr_priority
  import tri_bus_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   sel,
  output logic            any_req
);

  logic [NREQ-1:0] rot;
  logic [OW-1:0]   off;
  logic [OW:0]     sum;

  // Doubling the vector turns the wrap-around into a plain right shift.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    off     = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = OW'(i);
        any_req = 1'b1;
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign sel = (sum >= (OW + 1)'(NREQ)) ? OW'(sum - (OW + 1)'(NREQ)) : sum[OW-1:0];

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared 32-bit tristate bus: one-hot buffer enables,
// a forced dead cycle on every hand-over, and a hold-time limit.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [OW-1:0]   owner,
  output logic            timeout
);

  localparam int            CW       = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("tri_bus_arbiter: NREQ=%0d outside %0d..%0d", NREQ, NREQ_MIN, NREQ_MAX);
  end
  if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_hold
    $error("tri_bus_arbiter: MAX_HOLD=%0d outside %0d..%0d", MAX_HOLD, MAX_HOLD_MIN,
           MAX_HOLD_MAX);
  end

  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] sel;
  logic          any_req;
  logic [CW-1:0] cnt;
  logic          own_done;
  logic          own_drop;
  logic          hold_hit;
  logic          release_now;

  rr_priority #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  // Only the current owner's done/req bits matter while the bus is held.
  assign own_done    = done[owner];
  assign own_drop    = !req[owner];
  assign hold_hit    = (cnt == CNT_LAST);
  assign release_now = own_done || own_drop || hold_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge register values regardless of statement order.
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt   <= NREQ'(1) << sel;
            owner <= sel;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
            timeout <= hold_hit && !own_done && !own_drop;
            state   <= ST_TURN;
          end else if (!hold_hit) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_gnt_onehot0: assert property (@(posedge clock) $onehot0(gnt));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: a tenure-level reference model queues
// the expected outputs of every cycle, and a monitor compares them.
module tb_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;
  } obs_t;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  // Reference model: who holds the bus, for how many cycles so far, whether a
  // dead cycle is pending, and the requester that has first claim next.
  int m_owner;
  int m_last;
  int m_held;
  bit m_gap;
  int m_ptr;

  tri_bus_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_gap   = 1'b0;
    m_ptr   = 0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    obs_t e;
    bit   to;
    bit   by_done;
    bit   by_drop;
    bit   by_time;
    to = 1'b0;
    if (m_owner >= 0) begin
      by_done = d[m_owner];
      by_drop = !r[m_owner];
      by_time = (m_held == MH);
      if (by_done || by_drop || by_time) begin
        to      = by_time && !by_done && !by_drop;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (r[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_held  = 1;
          break;
        end
      end
    end
    e.gnt     = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.busy    = (m_owner >= 0);
    e.owner   = 2'(m_last);
    e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic drive_now(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    model_step(r, d);
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    @(negedge clock);
    drive_now(r, d);
  endtask

  task automatic run_until(input string name, input int o, input int h, input logic [3:0] r);
    int n;
    n = 0;
    while (!(m_owner == o && m_held == h) && n < 40) begin
      cycle(r, 4'b0000);
      n++;
    end
    check(name, 32'(m_owner == o && m_held == h), 32'd1);
  endtask

  // Monitor: every post-edge output set is compared with the oldest prediction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {gnt, busy, owner, timeout};
        check("outputs{gnt,busy,owner,timeout}", 32'(a), 32'(e));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] d;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 4'b0000;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    drive_now(4'b0000, 4'b0000);
    repeat (5) cycle(4'b0000, 4'b0000);

    // Single requester released by done, then ptr=3 steers the next grant.
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0100);
    repeat (2) cycle(4'b0000, 4'b0000);
    repeat (2) cycle(4'b1011, 4'b0000);
    repeat (3) cycle(4'b0000, 4'b0000);

    // Full contention: each owner pulses done in its first granted cycle.
    repeat (20) begin
      d = (m_owner >= 0 && m_held == 1) ? 4'(1 << m_owner) : 4'b0000;
      cycle(4'b1111, d);
    end
    repeat (3) cycle(4'b0000, 4'b0000);

    // Hold-limit revocation and re-grant of the same requester.
    repeat (14) cycle(4'b0010, 4'b0000);
    run_until("reach_owner1_hold7", 1, MH - 1, 4'b0010);
    cycle(4'b0010, 4'b1101);
    cycle(4'b0000, 4'b0010);
    repeat (3) cycle(4'b0000, 4'b0000);

    // Randomised traffic with sticky requests and sporadic done pulses.
    r = 4'b0000;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      cycle(r, d);
    end

    // Asynchronous reset while requester 3 holds the bus.
    run_until("reach_owner3", 3, 1, 4'b1000);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_gnt", 32'(gnt), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_owner", 32'(owner), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive_now(4'b1111, 4'b0000);
    @(posedge clock);
    #2;
    check("first_grant_after_reset", 32'(gnt), 32'd1);
    repeat (6) cycle(4'b1111, 4'b0000);
    repeat (3) cycle(4'b0000, 4'b0000);

    @(posedge clock);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
